// File: rtl/scalar_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scalar_mult_ctrl
// Description : Left-to-right double-and-add sequencer for Q = k*P on
//               y^2 = x^3 + a*x + b mod p. Drives an external point doubler
//               and point adder, tracks the running point R (including the
//               point at infinity) and reports Q with a one-cycle done.
// Options     : SCALAR_MULT_SKIP_LEADING_ZEROS_EN - start the bit scan at the
//               MSB of k instead of bit N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_mult_ctrl #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] p,
    input  logic [N-1:0] a,
    input  logic [N-1:0] k,
    input  logic [N-1:0] xp,
    input  logic [N-1:0] yp,
    output logic         dbl_start,
    output logic [N-1:0] dbl_x1,
    output logic [N-1:0] dbl_y1,
    output logic [N-1:0] dbl_p,
    output logic [N-1:0] dbl_a,
    input  logic [N-1:0] dbl_x3,
    input  logic [N-1:0] dbl_y3,
    input  logic         dbl_result,
    input  logic         dbl_infinity,
    output logic         add_start,
    output logic [N-1:0] add_x1,
    output logic [N-1:0] add_y1,
    output logic [N-1:0] add_x2,
    output logic [N-1:0] add_y2,
    output logic [N-1:0] add_p,
    input  logic [N-1:0] add_x3,
    input  logic [N-1:0] add_y3,
    input  logic         add_result,
    input  logic         add_infinity,
    output logic [N-1:0] x3,
    output logic [N-1:0] y3,
    output logic         infinity,
    output logic         busy,
    output logic         done
);

    localparam int               c_IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(N - 1);

    localparam logic [3:0] c_S_IDLE      = 4'd0;
    localparam logic [3:0] c_S_DBL       = 4'd1;
    localparam logic [3:0] c_S_DBL_WAIT  = 4'd2;
    localparam logic [3:0] c_S_BITCHK    = 4'd3;
    localparam logic [3:0] c_S_DBL2      = 4'd4;
    localparam logic [3:0] c_S_DBL2_WAIT = 4'd5;
    localparam logic [3:0] c_S_ADD_WAIT  = 4'd6;
    localparam logic [3:0] c_S_NEXT      = 4'd7;
    localparam logic [3:0] c_S_DONE      = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_next;

    logic [N-1:0]       r_p;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_k;
    logic [N-1:0]       r_xp;
    logic [N-1:0]       r_yp;
    logic [N-1:0]       r_rx;
    logic [N-1:0]       r_ry;
    logic               r_inf;
    logic [c_IDX_W-1:0] r_idx;
    logic [N-1:0]       r_x3;
    logic [N-1:0]       r_y3;
    logic               r_infinity;

    logic [c_IDX_W-1:0] w_start_idx;
    logic               w_start_to_done;
    logic               w_bit;
    logic               w_x_eq;
    logic               w_y_eq;

    assign w_bit  = r_k[r_idx];
    assign w_x_eq = (r_rx == r_xp);
    assign w_y_eq = (r_ry == r_yp);

`ifdef SCALAR_MULT_SKIP_LEADING_ZEROS_EN
    // Priority encoder: index of the most significant set bit of k
    always_comb begin
        w_start_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (k[i]) begin
                w_start_idx = c_IDX_W'(i);
            end
        end
    end
    assign w_start_to_done = (k == '0);
`else
    assign w_start_idx     = c_IDX_MAX;
    assign w_start_to_done = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_next = w_start_to_done ? c_S_DONE : c_S_DBL;
                end
            end
            c_S_DBL: begin
                w_next = r_inf ? c_S_BITCHK : c_S_DBL_WAIT;
            end
            c_S_DBL_WAIT: begin
                if (dbl_infinity || dbl_result) begin
                    w_next = c_S_BITCHK;
                end
            end
            c_S_BITCHK: begin
                if (!w_bit || r_inf) begin
                    w_next = c_S_NEXT;
                end else if (w_x_eq) begin
                    w_next = w_y_eq ? c_S_DBL2 : c_S_NEXT;
                end else begin
                    w_next = c_S_ADD_WAIT;
                end
            end
            c_S_DBL2: begin
                w_next = c_S_DBL2_WAIT;
            end
            c_S_DBL2_WAIT: begin
                if (dbl_infinity || dbl_result) begin
                    w_next = c_S_NEXT;
                end
            end
            c_S_ADD_WAIT: begin
                if (add_infinity || add_result) begin
                    w_next = c_S_NEXT;
                end
            end
            c_S_NEXT: begin
                w_next = (r_idx == '0) ? c_S_DONE : c_S_DBL;
            end
            c_S_DONE: begin
                w_next = c_S_IDLE;
            end
            default: begin
                w_next = c_S_IDLE;
            end
        endcase
    end

    // Strobes and status decoded from the current state
    always_comb begin
        dbl_start = 1'b0;
        add_start = 1'b0;
        busy      = (r_state != c_S_IDLE);
        done      = (r_state == c_S_DONE);
        if ((r_state == c_S_DBL && !r_inf) || r_state == c_S_DBL2) begin
            dbl_start = 1'b1;
        end
        if (r_state == c_S_BITCHK && w_bit && !r_inf && !w_x_eq) begin
            add_start = 1'b1;
        end
    end

    // Operand latches, running point R, scan index and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p        <= '0;
            r_a        <= '0;
            r_k        <= '0;
            r_xp       <= '0;
            r_yp       <= '0;
            r_rx       <= '0;
            r_ry       <= '0;
            r_inf      <= 1'b1;
            r_idx      <= c_IDX_MAX;
            r_x3       <= '0;
            r_y3       <= '0;
            r_infinity <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_p        <= p;
                        r_a        <= a;
                        r_k        <= k;
                        r_xp       <= xp;
                        r_yp       <= yp;
                        r_inf      <= 1'b1;
                        r_idx      <= w_start_idx;
                        r_x3       <= '0;
                        r_y3       <= '0;
                        // k=0 with the skip option lands in DONE directly
                        r_infinity <= w_start_to_done;
                    end
                end
                c_S_DBL_WAIT, c_S_DBL2_WAIT: begin
                    // Infinity takes priority over a simultaneous result
                    if (dbl_infinity) begin
                        r_inf <= 1'b1;
                    end else if (dbl_result) begin
                        r_rx <= dbl_x3;
                        r_ry <= dbl_y3;
                    end
                end
                c_S_ADD_WAIT: begin
                    if (add_infinity) begin
                        r_inf <= 1'b1;
                    end else if (add_result) begin
                        r_rx <= add_x3;
                        r_ry <= add_y3;
                    end
                end
                c_S_BITCHK: begin
                    if (w_bit) begin
                        if (r_inf) begin
                            r_rx  <= r_xp;
                            r_ry  <= r_yp;
                            r_inf <= 1'b0;
                        end else if (w_x_eq && !w_y_eq) begin
                            // R = -P, so R + P is the point at infinity
                            r_inf <= 1'b1;
                        end
                    end
                end
                c_S_NEXT: begin
                    if (r_idx == '0) begin
                        r_x3       <= r_inf ? '0 : r_rx;
                        r_y3       <= r_inf ? '0 : r_ry;
                        r_infinity <= r_inf;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dbl_x1   = r_rx;
    assign dbl_y1   = r_ry;
    assign dbl_p    = r_p;
    assign dbl_a    = r_a;
    assign add_x1   = r_rx;
    assign add_y1   = r_ry;
    assign add_x2   = r_xp;
    assign add_y2   = r_yp;
    assign add_p    = r_p;
    assign x3       = r_x3;
    assign y3       = r_y3;
    assign infinity = r_infinity;

endmodule
`default_nettype wire

// File: tb/tb_scalar_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalar_mult_ctrl
// Description : Directed bench for scalar_mult_ctrl on y^2 = x^3 + 2x + 2
//               mod 17 with P = (6,3), using behavioural doubler/adder models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_mult_ctrl;

    localparam int N = 10;

`ifdef SCALAR_MULT_SKIP_LEADING_ZEROS_EN
    localparam int c_K0_CYC = 0;
    localparam int c_K1_CYC = 3;
`else
    localparam int c_K0_CYC = 30;
    localparam int c_K1_CYC = 30;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] p, a, k, xp, yp;
    logic         dbl_start;
    logic [N-1:0] dbl_x1, dbl_y1, dbl_p, dbl_a;
    logic [N-1:0] dbl_x3 = '0, dbl_y3 = '0;
    logic         dbl_result = 1'b0, dbl_infinity = 1'b0;
    logic         add_start;
    logic [N-1:0] add_x1, add_y1, add_x2, add_y2, add_p;
    logic [N-1:0] add_x3 = '0, add_y3 = '0;
    logic         add_result = 1'b0, add_infinity = 1'b0;
    logic [N-1:0] x3, y3;
    logic         infinity, busy, done;

    int checks = 0;
    int errors = 0;

    scalar_mult_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .p(p), .a(a), .k(k), .xp(xp), .yp(yp),
        .dbl_start(dbl_start), .dbl_x1(dbl_x1), .dbl_y1(dbl_y1),
        .dbl_p(dbl_p), .dbl_a(dbl_a), .dbl_x3(dbl_x3), .dbl_y3(dbl_y3),
        .dbl_result(dbl_result), .dbl_infinity(dbl_infinity),
        .add_start(add_start), .add_x1(add_x1), .add_y1(add_y1),
        .add_x2(add_x2), .add_y2(add_y2), .add_p(add_p),
        .add_x3(add_x3), .add_y3(add_y3),
        .add_result(add_result), .add_infinity(add_infinity),
        .x3(x3), .y3(y3), .infinity(infinity), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int modp(input int v, input int m);
        int r;
        r = v % m;
        if (r < 0) r = r + m;
        return r;
    endfunction

    // Fermat inverse, v in [1, m-1], m prime
    function automatic int inv(input int v, input int m);
        int r;
        r = 1;
        for (int e = 0; e < m - 2; e++) r = (r * v) % m;
        return r;
    endfunction

    // Unit request bookkeeping
    int n_dbl = 0, n_add = 0, n_done = 0;
    logic [N-1:0] last_dbl_x = '0, last_dbl_y = '0;
    logic [N-1:0] last_add_x1 = '0, last_add_y1 = '0, last_add_x2 = '0, last_add_y2 = '0;

    always @(posedge clk) begin
        if (done) n_done <= n_done + 1;
    end

    // Behavioural doubler, 4-cycle latency
    int dbl_cnt = 0;
    logic [N-1:0] dm_x, dm_y, dm_p, dm_a;
    always @(posedge clk) begin
        int m, x, y, lam, xr, yr;
        dbl_result   <= 1'b0;
        dbl_infinity <= 1'b0;
        if (dbl_start) begin
            dbl_cnt    <= 4;
            dm_x       <= dbl_x1;
            dm_y       <= dbl_y1;
            dm_p       <= dbl_p;
            dm_a       <= dbl_a;
            n_dbl      <= n_dbl + 1;
            last_dbl_x <= dbl_x1;
            last_dbl_y <= dbl_y1;
        end else if (dbl_cnt != 0) begin
            dbl_cnt <= dbl_cnt - 1;
            if (dbl_cnt == 1) begin
                m = int'(dm_p);
                x = int'(dm_x);
                y = int'(dm_y);
                if (y == 0) begin
                    dbl_infinity <= 1'b1;
                end else begin
                    lam = modp(modp(3 * x * x + int'(dm_a), m) * inv(modp(2 * y, m), m), m);
                    xr  = modp(lam * lam - 2 * x, m);
                    yr  = modp(lam * (x - xr) - y, m);
                    dbl_x3     <= N'(xr);
                    dbl_y3     <= N'(yr);
                    dbl_result <= 1'b1;
                end
            end
        end
    end

    // Behavioural adder, 4-cycle latency
    int add_cnt = 0;
    logic [N-1:0] am_x1, am_y1, am_x2, am_y2, am_p;
    always @(posedge clk) begin
        int m, lam, xr, yr;
        add_result   <= 1'b0;
        add_infinity <= 1'b0;
        if (add_start) begin
            add_cnt     <= 4;
            am_x1       <= add_x1;
            am_y1       <= add_y1;
            am_x2       <= add_x2;
            am_y2       <= add_y2;
            am_p        <= add_p;
            n_add       <= n_add + 1;
            last_add_x1 <= add_x1;
            last_add_y1 <= add_y1;
            last_add_x2 <= add_x2;
            last_add_y2 <= add_y2;
        end else if (add_cnt != 0) begin
            add_cnt <= add_cnt - 1;
            if (add_cnt == 1) begin
                m = int'(am_p);
                if (am_x1 == am_x2) begin
                    add_infinity <= 1'b1;
                end else begin
                    lam = modp(modp(int'(am_y2) - int'(am_y1), m) *
                               inv(modp(int'(am_x2) - int'(am_x1), m), m), m);
                    xr  = modp(lam * lam - int'(am_x1) - int'(am_x2), m);
                    yr  = modp(lam * (int'(am_x1) - xr) - int'(am_y1), m);
                    add_x3     <= N'(xr);
                    add_y3     <= N'(yr);
                    add_result <= 1'b1;
                end
            end
        end
    end

    // Results of the most recent run_op
    int           res_cyc, res_ndbl, res_nadd;
    logic         res_seen, res_busy, res_done2, res_busy2, res_inf;
    logic [N-1:0] res_x, res_y;

    // Issue one multiplication and wait (bounded) for done
    task automatic run_op(input logic [N-1:0] kv);
        int d0, a0;
        d0 = n_dbl;
        a0 = n_add;
        @(negedge clk);
        k     = kv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        res_busy = busy;
        res_cyc  = 0;
        res_seen = done;
        while (!res_seen && res_cyc < 1000) begin
            @(posedge clk);
            #1;
            res_cyc++;
            if (done) res_seen = 1'b1;
        end
        res_x   = x3;
        res_y   = y3;
        res_inf = infinity;
        @(posedge clk);
        #1;
        res_done2 = done;
        res_busy2 = busy;
        res_ndbl  = n_dbl - d0;
        res_nadd  = n_add - a0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        p = 10'd17; a = 10'd2; k = '0; xp = 10'd6; yp = 10'd3;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (infinity !== 1'b0) begin errors++; $display("FAIL reset_inf got %0b want 0", infinity); end
        checks++; if (x3 !== '0 || y3 !== '0) begin errors++; $display("FAIL reset_xy got (%0d,%0d) want (0,0)", x3, y3); end
        checks++; if (dbl_start !== 1'b0 || add_start !== 1'b0) begin errors++; $display("FAIL reset_strobes got %0b%0b want 00", dbl_start, add_start); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_k0();
        run_op(10'd0);
        checks++; if (res_seen !== 1'b1) begin errors++; $display("FAIL k0_done got timeout want done"); end
        checks++; if (res_cyc != c_K0_CYC) begin errors++; $display("FAIL k0_latency got %0d want %0d", res_cyc, c_K0_CYC); end
        checks++; if (res_inf !== 1'b1) begin errors++; $display("FAIL k0_inf got %0b want 1", res_inf); end
        checks++; if (res_x !== '0 || res_y !== '0) begin errors++; $display("FAIL k0_xy got (%0d,%0d) want (0,0)", res_x, res_y); end
        checks++; if (res_ndbl != 0 || res_nadd != 0) begin errors++; $display("FAIL k0_requests got %0d/%0d want 0/0", res_ndbl, res_nadd); end
        checks++; if (res_busy !== 1'b1) begin errors++; $display("FAIL k0_busy got %0b want 1", res_busy); end
        checks++; if (res_done2 !== 1'b0 || res_busy2 !== 1'b0) begin errors++; $display("FAIL k0_done_width got done=%0b busy=%0b want 0/0", res_done2, res_busy2); end
    endtask

    task automatic test_k2();
        run_op(10'd2);
        checks++; if (res_seen !== 1'b1) begin errors++; $display("FAIL k2_done got timeout want done"); end
        checks++; if (res_ndbl != 1 || res_nadd != 0) begin errors++; $display("FAIL k2_requests got %0d/%0d want 1/0", res_ndbl, res_nadd); end
        checks++; if (last_dbl_x !== 10'd6 || last_dbl_y !== 10'd3) begin errors++; $display("FAIL k2_dbl_operands got (%0d,%0d) want (6,3)", last_dbl_x, last_dbl_y); end
        checks++; if (res_x !== 10'd3 || res_y !== 10'd1 || res_inf !== 1'b0) begin errors++; $display("FAIL k2_result got (%0d,%0d,%0b) want (3,1,0)", res_x, res_y, res_inf); end
    endtask

    task automatic test_k3();
        run_op(10'd3);
        checks++; if (res_seen !== 1'b1) begin errors++; $display("FAIL k3_done got timeout want done"); end
        checks++; if (res_ndbl != 1 || res_nadd != 1) begin errors++; $display("FAIL k3_requests got %0d/%0d want 1/1", res_ndbl, res_nadd); end
        checks++; if (last_add_x1 !== 10'd3 || last_add_y1 !== 10'd1 || last_add_x2 !== 10'd6 || last_add_y2 !== 10'd3) begin
            errors++; $display("FAIL k3_add_operands got (%0d,%0d)+(%0d,%0d) want (3,1)+(6,3)", last_add_x1, last_add_y1, last_add_x2, last_add_y2); end
        checks++; if (res_x !== 10'd16 || res_y !== 10'd13 || res_inf !== 1'b0) begin errors++; $display("FAIL k3_result got (%0d,%0d,%0b) want (16,13,0)", res_x, res_y, res_inf); end
    endtask

    task automatic test_k19_neg();
        run_op(10'd19);
        checks++; if (res_seen !== 1'b1) begin errors++; $display("FAIL k19_done got timeout want done"); end
        checks++; if (res_inf !== 1'b1 || res_x !== '0 || res_y !== '0) begin errors++; $display("FAIL k19_result got (%0d,%0d,%0b) want (0,0,1)", res_x, res_y, res_inf); end
        checks++; if (res_ndbl != 4 || res_nadd != 1) begin errors++; $display("FAIL k19_requests got %0d/%0d want 4/1", res_ndbl, res_nadd); end
    endtask

    task automatic test_k21_equal();
        run_op(10'd21);
        checks++; if (res_seen !== 1'b1) begin errors++; $display("FAIL k21_done got timeout want done"); end
        checks++; if (res_x !== 10'd3 || res_y !== 10'd1 || res_inf !== 1'b0) begin errors++; $display("FAIL k21_result got (%0d,%0d,%0b) want (3,1,0)", res_x, res_y, res_inf); end
        checks++; if (res_ndbl != 5 || res_nadd != 1) begin errors++; $display("FAIL k21_requests got %0d/%0d want 5/1", res_ndbl, res_nadd); end
        checks++; if (last_dbl_x !== 10'd6 || last_dbl_y !== 10'd3) begin errors++; $display("FAIL k21_last_dbl got (%0d,%0d) want (6,3)", last_dbl_x, last_dbl_y); end
    endtask

    task automatic test_midrun_reset();
        int done0;
        done0 = n_done;
        @(negedge clk);
        k     = 10'd21;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_async got busy=%0b done=%0b want 0/0", busy, done); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (n_done != done0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", n_done - done0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%0b want 0", busy); end
        run_op(10'd2);
        checks++; if (res_seen !== 1'b1) begin errors++; $display("FAIL rerun_done got timeout want done"); end
        checks++; if (res_x !== 10'd3 || res_y !== 10'd1 || res_inf !== 1'b0) begin errors++; $display("FAIL rerun_result got (%0d,%0d,%0b) want (3,1,0)", res_x, res_y, res_inf); end
    endtask

    task automatic test_k1();
        run_op(10'd1);
        checks++; if (res_seen !== 1'b1) begin errors++; $display("FAIL k1_done got timeout want done"); end
        checks++; if (res_cyc != c_K1_CYC) begin errors++; $display("FAIL k1_latency got %0d want %0d", res_cyc, c_K1_CYC); end
        checks++; if (res_x !== 10'd6 || res_y !== 10'd3 || res_inf !== 1'b0) begin errors++; $display("FAIL k1_result got (%0d,%0d,%0b) want (6,3,0)", res_x, res_y, res_inf); end
        checks++; if (res_ndbl != 0 || res_nadd != 0) begin errors++; $display("FAIL k1_requests got %0d/%0d want 0/0", res_ndbl, res_nadd); end
    endtask

    initial begin
        test_reset();
        test_k0();
        test_k2();
        test_k3();
        test_k19_neg();
        test_k21_equal();
        test_midrun_reset();
        test_k1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
- Left-to-right double-and-add sequencer that computes Q = k·P on y² = x³ + a·x + b mod p.
- Sits directly upstream of the point_doubling unit and a point_addition unit. It drives their operands and start strobes, and consumes their x3/y3/result/infinity outputs.
- It holds the running point R, handles the point at infinity and the special cases, and reports Q with a one-cycle done strobe.

Parameters:
- n, 10, bit width of coordinates, p, a and scalar k

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- p  in  n  field prime, latched at start
- a  in  n  curve coefficient, latched at start
- k  in  n  scalar, latched at start
- xp, yp  in  n each  base point P, latched at start
- dbl_start  out  1  one-cycle pulse, wired to the doubler's reset (the doubler restarts on release)
- dbl_x1, dbl_y1, dbl_p, dbl_a  out  n each  doubler operands, stable from pulse until response
- dbl_x3, dbl_y3  in  n each  doubler result
- dbl_result, dbl_infinity  in  1 each  doubler completion flags
- add_start  out  1  one-cycle pulse to the adder
- add_x1, add_y1, add_x2, add_y2, add_p  out  n each  adder operands (R, P, p)
- add_x3, add_y3  in  n each  adder result
- add_result, add_infinity  in  1 each  adder completion flags
- x3, y3  out  n each  result Q; held until the next start
- infinity  out  1  Q is the point at infinity; held
- busy  out  1  high from the start-sampling edge until DONE exits
- done  out  1  high for exactly one cycle, while in DONE

Behaviour:
- Reset, any state: go to IDLE. All outputs 0, r_inf=1, idx=n-1.
- Reset mid-operation aborts without done. Late unit responses are ignored while in IDLE.
- IDLE: on start, latch inputs; set r_inf=1, idx=n-1, busy=1; go to DBL. start is ignored outside IDLE.
- DBL:
  - If r_inf, go to BITCHK (no request; 2·∞ = ∞).
  - Otherwise pulse dbl_start with (rx, ry) and go to DBL_WAIT.
- DBL_WAIT: wait for the unit.
  - dbl_infinity: set r_inf=1.
  - dbl_result: load rx, ry from dbl_x3, dbl_y3.
  - Either way, go to BITCHK. If both flags are high in the same cycle, infinity wins.
- BITCHK, when k[idx]=0: go to NEXT.
- BITCHK, when k[idx]=1:
  - r_inf: load R=P, clear r_inf, go to NEXT.
  - rx==xp and ry==yp: go to DBL2. This pulses dbl_start with R, then waits exactly as in DBL_WAIT.
  - rx==xp and ry!=yp: set r_inf=1 (R = −P), go to NEXT.
  - Otherwise: pulse add_start and go to ADD_WAIT. ADD_WAIT mirrors DBL_WAIT using the add_* flags.
- NEXT: if idx==0, go to DONE; otherwise decrement idx and go to DBL.
- DONE: x3=rx, y3=ry, infinity=r_inf, done=1; go to IDLE. busy clears on that edge. When infinity=1, x3 and y3 are 0.
- Timing: every non-wait state lasts exactly 1 cycle. k=0 gives done high in the cycle after the 3n-th edge following the start-sampling edge (n=10 gives 30).
- Width rules: k is unsigned and all comparisons are full n-bit. No modular arithmetic is performed in this block.

Optional Feature:
- Macro: SCALAR_MULT_SKIP_LEADING_ZEROS_EN.
- Defined: at start, a priority encoder sets idx to the index of the MSB of k.
  - k=0 goes straight to DONE, so done is high in the cycle after the start edge.
  - k=1 gives done 3 cycles after start, with no unit requests.
- Undefined: idx always starts at n-1, and leading zero bits cost 3 cycles each.
- Results are identical either way.

Test Plan:
- Common setup: n=10, p=17, a=2, P=(6,3). Bench uses behavioural mod-17 doubler/adder models with 4-cycle latency.
- k=0, feature off -> done 30 cycles after start, infinity=1, zero dbl_start/add_start pulses.
- k=2 -> one dbl_start with (6,3); result (3,1), infinity=0.
- k=3 -> add request with R=(3,1), P=(6,3); result (16,13).
- k=19 (point order) -> final step takes the R=−P path: infinity=1, and no add_start in that step.
- k=21 -> final step sees R==P, routes to the doubler instead of the adder; result (3,1).
- Mid-run reset, then start with k=2 -> no done from the aborted run; second run returns (3,1).
- Feature on, k=1 -> done 3 cycles after start, result (6,3).
